// File: rtl/s3g_rx.sv
// s3g_rx: byte-level receiver/framer for S3G host packets.
//
// Sits between the UART receiver and the command executor. It hunts for the
// 0xD5 start byte, takes a length byte L (0..16), collects L payload bytes
// into a parallel buffer and compares the trailing byte against a CRC8
// (Dallas/Maxim, reflected poly 0x8C, init 0) computed over the payload only.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   rx_data[7:0]  in   received byte, qualified by rx_done
//   rx_done       in   one-cycle strobe, rx_data holds a new byte
//   packet_done   out  one-cycle pulse: CRC-good packet received
//   packet_error  out  one-cycle pulse: CRC mismatch or length > 16
//   payload_len   out  length byte of the last packet that reached LEN
//   buffer_valid  out  high while buf0..buf15 hold a CRC-checked payload
//   buf0..buf15   out  payload bytes, buf0 = first byte; unused bytes read 0
//   dbg_state     out  current FSM state (0 IDLE, 1 LEN, 2 PAYLOAD, 3 CRC)
//
// Handshake: a byte is consumed on a rising edge only when rx_done=1; there
// is no ready/back-pressure, so strobes may arrive on consecutive cycles.

module s3g_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       packet_done,
  output logic       packet_error,
  output logic [7:0] payload_len,
  output logic       buffer_valid,
  output logic [7:0] buf0,
  output logic [7:0] buf1,
  output logic [7:0] buf2,
  output logic [7:0] buf3,
  output logic [7:0] buf4,
  output logic [7:0] buf5,
  output logic [7:0] buf6,
  output logic [7:0] buf7,
  output logic [7:0] buf8,
  output logic [7:0] buf9,
  output logic [7:0] buf10,
  output logic [7:0] buf11,
  output logic [7:0] buf12,
  output logic [7:0] buf13,
  output logic [7:0] buf14,
  output logic [7:0] buf15,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  localparam logic [7:0] START_BYTE = 8'hD5;

  state_t     state_q;
  logic [3:0] index_q;
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] len_q;
  logic       done_q;
  logic       error_q;
  logic       valid_q;
  logic [7:0] buf_q [16];

  // One byte of the reflected Dallas/Maxim CRC8.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc8_next(crc_q, rx_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      index_q <= 4'd0;
      crc_q   <= 8'd0;
      len_q   <= 8'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= 8'd0;
    end else begin
      // Status outputs are single-cycle pulses.
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (rx_done) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == START_BYTE) begin
              valid_q <= 1'b0;
              crc_q   <= 8'd0;
              for (int i = 0; i < 16; i++) buf_q[i] <= 8'd0;
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            len_q   <= rx_data;
            index_q <= 4'd0;
            if (rx_data == 8'd0) begin
              state_q <= ST_CRC;
            end else if (rx_data <= 8'd16) begin
              state_q <= ST_PAYLOAD;
            end else begin
              error_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            // 0xD5 here is plain data; only IDLE hunts for the start byte.
            buf_q[index_q] <= rx_data;
            crc_q          <= crc_d;
            if ({4'd0, index_q} == (len_q - 8'd1)) begin
              state_q <= ST_CRC;
            end else begin
              index_q <= index_q + 4'd1;
            end
          end
          ST_CRC: begin
            if (rx_data == crc_q) begin
              done_q  <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign packet_done  = done_q;
  assign packet_error = error_q;
  assign payload_len  = len_q;
  assign buffer_valid = valid_q;
  assign dbg_state    = state_q;

  assign buf0  = buf_q[0];
  assign buf1  = buf_q[1];
  assign buf2  = buf_q[2];
  assign buf3  = buf_q[3];
  assign buf4  = buf_q[4];
  assign buf5  = buf_q[5];
  assign buf6  = buf_q[6];
  assign buf7  = buf_q[7];
  assign buf8  = buf_q[8];
  assign buf9  = buf_q[9];
  assign buf10 = buf_q[10];
  assign buf11 = buf_q[11];
  assign buf12 = buf_q[12];
  assign buf13 = buf_q[13];
  assign buf14 = buf_q[14];
  assign buf15 = buf_q[15];

endmodule

// File: tb/tb_s3g_rx.sv
// Testbench for s3g_rx: table of directed packets with hand-computed results,
// plus hand-written sequences for reset state and reset mid-packet.

module tb_s3g_rx;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       packet_done;
  logic       packet_error;
  logic [7:0] payload_len;
  logic       buffer_valid;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7;
  logic [7:0] b8, b9, b10, b11, b12, b13, b14, b15;
  logic [1:0] dbg_state;

  s3g_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .packet_done  (packet_done),
    .packet_error (packet_error),
    .payload_len  (payload_len),
    .buffer_valid (buffer_valid),
    .buf0 (b0),  .buf1 (b1),  .buf2 (b2),  .buf3 (b3),
    .buf4 (b4),  .buf5 (b5),  .buf6 (b6),  .buf7 (b7),
    .buf8 (b8),  .buf9 (b9),  .buf10(b10), .buf11(b11),
    .buf12(b12), .buf13(b13), .buf14(b14), .buf15(b15),
    .dbg_state    (dbg_state)
  );

  // Element [i] is buf i.
  logic [15:0][7:0] bufs;
  assign bufs = {b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (packet_done)  done_cnt++;
    if (packet_error) err_cnt++;
    if (packet_done && packet_error) both_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [19:0][7:0] b;
    logic [4:0]       n;
    logic [3:0]       gap;
    logic             exp_done;
    logic             exp_err;
    logic             exp_valid;
    logic [7:0]       exp_len;
    logic [15:0][7:0] exp_buf;
  } vec_t;

  vec_t vecs[$];
  vec_t t;

  task automatic start_vec(input int gap);
    t = '0;
    t.gap = gap[3:0];
  endtask

  task automatic put(input logic [7:0] x);
    t.b[t.n] = x;
    t.n = t.n + 5'd1;
  endtask

  task automatic commit(input logic d, input logic e, input logic v, input logic [7:0] len);
    t.exp_done  = d;
    t.exp_err   = e;
    t.exp_valid = v;
    t.exp_len   = len;
    vecs.push_back(t);
  endtask

  // ---------------- driver ----------------
  // Drive one byte for one rising edge; if it is the last byte of a packet,
  // check the status pulse in the cycle right after that edge.
  task automatic send_byte(input logic [7:0] x, input int gap, input bit last,
                           input logic ed, input logic ee, input string tag);
    rx_data = x;
    rx_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_done = 1'b0;
    if (last) begin
      chk({tag, " latency done"}, {127'd0, packet_done}, {127'd0, ed});
      chk({tag, " latency error"}, {127'd0, packet_error}, {127'd0, ee});
    end
    // Garbage on rx_data while rx_done=0 must be ignored.
    repeat (gap) begin
      rx_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    done_cnt = 0;
    err_cnt  = 0;
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.b[i], v.gap, (i == v.n - 1), v.exp_done, v.exp_err, tag);
    end
    repeat (3) @(negedge clk);
    chk({tag, " done count"},  done_cnt,  {127'd0, v.exp_done});
    chk({tag, " error count"}, err_cnt,   {127'd0, v.exp_err});
    chk({tag, " payload_len"}, payload_len, v.exp_len);
    chk({tag, " buffer_valid"}, buffer_valid, v.exp_valid);
    chk({tag, " bufs"}, bufs, v.exp_buf);
    chk({tag, " state idle"}, dbg_state, 2'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    rst     = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;

    // 0: noise byte then bad CRC -> error, buffer not valid, data retained
    start_vec(1);
    put(8'h0D); put(8'hD5); put(8'h03); put(8'h01); put(8'h02); put(8'h03); put(8'hCC);
    t.exp_buf[0] = 8'h01; t.exp_buf[1] = 8'h02; t.exp_buf[2] = 8'h03;
    commit(1'b0, 1'b1, 1'b0, 8'd3);
    // 1: good packet 01 02 03, CRC D8
    start_vec(1);
    put(8'hD5); put(8'h03); put(8'h01); put(8'h02); put(8'h03); put(8'hD8);
    t.exp_buf[0] = 8'h01; t.exp_buf[1] = 8'h02; t.exp_buf[2] = 8'h03;
    commit(1'b1, 1'b0, 1'b1, 8'd3);
    // 2: leading zero payload byte, CRC 78
    start_vec(2);
    put(8'hD5); put(8'h03); put(8'h00); put(8'h01); put(8'h02); put(8'h78);
    t.exp_buf[0] = 8'h00; t.exp_buf[1] = 8'h01; t.exp_buf[2] = 8'h02;
    commit(1'b1, 1'b0, 1'b1, 8'd3);
    // 3: 1B 01 02, CRC F3
    start_vec(0);
    put(8'hD5); put(8'h03); put(8'h1B); put(8'h01); put(8'h02); put(8'hF3);
    t.exp_buf[0] = 8'h1B; t.exp_buf[1] = 8'h01; t.exp_buf[2] = 8'h02;
    commit(1'b1, 1'b0, 1'b1, 8'd3);
    // 4: strobes 5 cycles apart, 3D 0D, CRC 59
    start_vec(4);
    put(8'hD5); put(8'h02); put(8'h3D); put(8'h0D); put(8'h59);
    t.exp_buf[0] = 8'h3D; t.exp_buf[1] = 8'h0D;
    commit(1'b1, 1'b0, 1'b1, 8'd2);
    // 5: length 17 -> error at length, valid and buffer cleared
    start_vec(1);
    put(8'hD5); put(8'h11);
    commit(1'b0, 1'b1, 1'b0, 8'h11);
    // 6: D5 as payload data, CRC(D5)=68
    start_vec(1);
    put(8'hD5); put(8'h01); put(8'hD5); put(8'h68);
    t.exp_buf[0] = 8'hD5;
    commit(1'b1, 1'b0, 1'b1, 8'd1);
    // 7: same payload, wrong CRC
    start_vec(0);
    put(8'hD5); put(8'h01); put(8'hD5); put(8'h00);
    t.exp_buf[0] = 8'hD5;
    commit(1'b0, 1'b1, 1'b0, 8'd1);
    // 8: zero-length packet, CRC 00
    start_vec(1);
    put(8'hD5); put(8'h00); put(8'h00);
    commit(1'b1, 1'b0, 1'b1, 8'd0);
    // 9: maximum length 16: fifteen zeros then 01, CRC 5E
    start_vec(0);
    put(8'hD5); put(8'h10);
    for (int i = 0; i < 15; i++) put(8'h00);
    put(8'h01); put(8'h5E);
    t.exp_buf[15] = 8'h01;
    commit(1'b1, 1'b0, 1'b1, 8'd16);
    // 10: vector 1 again with back-to-back strobes
    start_vec(0);
    put(8'hD5); put(8'h03); put(8'h01); put(8'h02); put(8'h03); put(8'hD8);
    t.exp_buf[0] = 8'h01; t.exp_buf[1] = 8'h02; t.exp_buf[2] = 8'h03;
    commit(1'b1, 1'b0, 1'b1, 8'd3);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset done",   packet_done,  1'b0);
    chk("reset error",  packet_error, 1'b0);
    chk("reset len",    payload_len,  8'd0);
    chk("reset valid",  buffer_valid, 1'b0);
    chk("reset bufs",   bufs,         128'd0);
    chk("reset state",  dbg_state,    2'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset mid-packet: D5 03 01, then asynchronous reset between edges.
    done_cnt = 0;
    err_cnt  = 0;
    send_byte(8'hD5, 0, 1'b0, 1'b0, 1'b0, "midrst");
    send_byte(8'h03, 0, 1'b0, 1'b0, 1'b0, "midrst");
    send_byte(8'h01, 1, 1'b0, 1'b0, 1'b0, "midrst");
    chk("midrst len before", payload_len, 8'd3);
    chk("midrst buf0 before", b0, 8'h01);
    #2 rst = 1'b0;
    #1;
    chk("midrst len async", payload_len, 8'd0);
    chk("midrst bufs async", bufs, 128'd0);
    chk("midrst valid async", buffer_valid, 1'b0);
    chk("midrst state async", dbg_state, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst no done", done_cnt, 0);
    chk("midrst no error", err_cnt, 0);
    run_vec(vecs[1], "after_rst");

    // Stalled packet waits without any pulse.
    done_cnt = 0;
    err_cnt  = 0;
    send_byte(8'hD5, 0, 1'b0, 1'b0, 1'b0, "stall");
    send_byte(8'h02, 20, 1'b0, 1'b0, 1'b0, "stall");
    chk("stall no pulse", done_cnt + err_cnt, 0);
    chk("stall state payload", dbg_state, 2'd2);

    chk("done and error never together", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
